// File: rtl/nn_pkg.sv
// Shared constants and types for the NN front-end.
// Pixel binarization in the loader is enabled by PIXEL_BINARIZE_EN.
package nn_pkg;

   localparam int NUM_PIXELS = 784;
   localparam int ADDR_W     = 10;
   localparam int PIX_W      = 8;
   localparam int THRESHOLD  = 128;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      HOLD,
      DONE
   } loader_state_t;

endpackage

// File: rtl/pixel_addr_counter.sv
// SRAM read address counter for the pixel loader.
// Increments on request, cleared explicitly at end of frame.
module pixel_addr_counter #(
   parameter int NUM_PIXELS = nn_pkg::NUM_PIXELS,
   parameter int ADDR_W     = nn_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              incr,
   input  logic              clr,
   output logic [ADDR_W-1:0] addr,
   output logic              at_last
);

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;

   always_comb begin
      addr_d = addr_q;
      if (clr) begin
         addr_d = '0;
      end else if (incr) begin
         addr_d = addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr    = addr_q;
   assign at_last = (addr_q == ADDR_W'(NUM_PIXELS - 1));

endmodule

// File: rtl/sram_pixel_loader.sv
// Reads a complete frame from SRAM and streams it out pixel by pixel.
// Define PIXEL_BINARIZE_EN to threshold each pixel to all-ones/zero.
module sram_pixel_loader #(
   parameter int NUM_PIXELS = nn_pkg::NUM_PIXELS,
   parameter int ADDR_W     = nn_pkg::ADDR_W,
   parameter int PIX_W      = nn_pkg::PIX_W,
   parameter int READ_LAT   = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              frame_ready,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_rden,
   input  logic [PIX_W-1:0]  sram_q,
   output logic [PIX_W-1:0]  pix_data,
   output logic              pix_valid,
   output logic              pix_last,
   input  logic              pix_ready,
   output logic              busy,
   output logic              load_done
);

   import nn_pkg::*;

   localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_LAT - 1);

   loader_state_t     state_q, state_d;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [PIX_W-1:0]  pix_next;
   logic              incr, clr, at_last;

   pixel_addr_counter #(
      .NUM_PIXELS (NUM_PIXELS),
      .ADDR_W     (ADDR_W)
   ) u_addr (
      .clk     (clk),
      .reset_n (reset_n),
      .incr    (incr),
      .clr     (clr),
      .addr    (sram_addr),
      .at_last (at_last)
   );

`ifdef PIXEL_BINARIZE_EN
   assign pix_next = (sram_q >= PIX_W'(THRESHOLD)) ? '1 : '0;
`else
   assign pix_next = sram_q;
`endif

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      pix_d   = pix_q;
      incr    = 1'b0;
      clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (frame_ready) begin
               state_d = READ;
            end
         end
         READ: begin
            state_d = WAIT;
            wcnt_d  = WAIT_LOAD;
         end
         WAIT: begin
            // data is valid on the final latency cycle
            if (wcnt_q == '0) begin
               pix_d   = pix_next;
               state_d = HOLD;
            end else begin
               wcnt_d = wcnt_q - CNT_W'(1);
            end
         end
         HOLD: begin
            if (pix_ready) begin
               if (at_last) begin
                  state_d = DONE;
               end else begin
                  incr    = 1'b1;
                  state_d = READ;
               end
            end
         end
         DONE: begin
            clr     = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         pix_q   <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         pix_q   <= pix_d;
      end
   end

   assign sram_rden = (state_q == READ);
   assign pix_valid = (state_q == HOLD);
   assign pix_last  = pix_valid && at_last;
   assign busy      = (state_q != IDLE);
   assign load_done = (state_q == DONE);
   assign pix_data  = pix_q;

endmodule

// File: tb/tb_sram_pixel_loader.sv
// Scoreboard bench for sram_pixel_loader with a 4-pixel frame.
// Expected pixels follow PIXEL_BINARIZE_EN when it is defined.
module tb_sram_pixel_loader;

   localparam int NP = 4;
   localparam int AW = 10;
   localparam int PW = 8;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          frame_ready = 1'b0;
   logic [AW-1:0] sram_addr;
   logic          sram_rden;
   logic [PW-1:0] sram_q = '0;
   logic [PW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_last;
   logic          pix_ready = 1'b0;
   logic          busy;
   logic          load_done;

   logic [PW-1:0] mem [NP];
   logic [PW-1:0] p1 = '0;

   typedef struct packed {
      logic [PW-1:0] data;
      logic          last;
   } exp_t;

   exp_t exp_q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int t0 = 0;
   int done_total = 0;
   int done_cyc = 0;
   int rden_total = 0;
   int hs_total = 0;

   sram_pixel_loader #(
      .NUM_PIXELS (NP),
      .ADDR_W     (AW),
      .PIX_W      (PW),
      .READ_LAT   (RL)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .frame_ready (frame_ready),
      .sram_addr   (sram_addr),
      .sram_rden   (sram_rden),
      .sram_q      (sram_q),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_last    (pix_last),
      .pix_ready   (pix_ready),
      .busy        (busy),
      .load_done   (load_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // two-stage read pipe; a read without the strobe returns junk
   always @(posedge clk) begin
      p1     <= sram_rden ? mem[sram_addr[1:0]] : 8'hEE;
      sram_q <= p1;
   end

   function automatic logic [PW-1:0] exp_pix(input int i);
      logic [PW-1:0] raw [NP];
      raw[0] = 8'd10;
      raw[1] = 8'd200;
      raw[2] = 8'd128;
      raw[3] = 8'd127;
`ifdef PIXEL_BINARIZE_EN
      return (raw[i] >= 8'd128) ? 8'hFF : 8'h00;
`else
      return raw[i];
`endif
   endfunction

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic push_frame();
      exp_t e;
      for (int i = 0; i < NP; i++) begin
         e.data = exp_pix(i);
         e.last = (i == NP - 1);
         exp_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sram_rden) rden_total++;
      if (load_done) begin
         done_total++;
         done_cyc = cyc;
      end
      if (pix_valid && pix_ready) begin
         hs_total++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_extra: got %0d with no expected pixel",
                     pix_data);
         end else begin
            e = exp_q.pop_front();
            if (pix_data != e.data || pix_last != e.last) begin
               fails++;
               $display("FAIL sb_pixel: got %0d/%0b expected %0d/%0b",
                        pix_data, pix_last, e.data, e.last);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      frame_ready = 1'b1;
      t0 = cyc;
      tick();
      frame_ready = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!pix_valid && n < 40) begin
         tick();
         n++;
      end
      if (!pix_valid) chk(name, 0, 1);
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_total < target && n < 200) begin
         tick();
         n++;
      end
      if (done_total < target) chk("done_timeout", done_total, target);
      tick();
   endtask

   task automatic accept_one();
      pix_ready = 1'b1;
      tick();
      pix_ready = 1'b0;
   endtask

   task automatic check_zero(input string name);
      chk({name, "_addr"}, int'(sram_addr), 0);
      chk({name, "_rden"}, int'(sram_rden), 0);
      chk({name, "_data"}, int'(pix_data), 0);
      chk({name, "_valid"}, int'(pix_valid), 0);
      chk({name, "_last"}, int'(pix_last), 0);
      chk({name, "_busy"}, int'(busy), 0);
      chk({name, "_done"}, int'(load_done), 0);
   endtask

   task automatic first_valid_at(input string name, input int req);
      int n;
      n = 0;
      while (!pix_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(name, cyc - t0, req);
   endtask

   initial begin
      int d0, r0, h0;
      mem[0] = 8'd10;
      mem[1] = 8'd200;
      mem[2] = 8'd128;
      mem[3] = 8'd127;

      #2;
      check_zero("rst");
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      check_zero("post_rst");

      // basic load
      push_frame();
      pix_ready = 1'b1;
      start();
      first_valid_at("basic_first_valid", 2 + RL);
      d0 = 0;
      wait_done(1);
      chk("basic_done_cyc", done_cyc - t0, NP * (RL + 2) + 1);
      chk("basic_done_cnt", done_total, 1);
      chk("basic_sb_empty", exp_q.size(), 0);
      chk("basic_idle", int'(busy), 0);

      // backpressure on pixel 1
      tick();
      pix_ready = 1'b0;
      push_frame();
      d0 = done_total;
      start();
      wait_valid("bp_valid0");
      accept_one();
      wait_valid("bp_valid1");
      r0 = rden_total;
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold_data", int'(pix_data), int'(exp_pix(1)));
         chk("bp_hold_valid", int'(pix_valid), 1);
      end
      chk("bp_no_rden", rden_total, r0);
      tick();
      pix_ready = 1'b1;
      wait_done(d0 + 1);
      chk("bp_sb_empty", exp_q.size(), 0);

      // frame_ready while busy is dropped
      tick();
      push_frame();
      d0 = done_total;
      h0 = hs_total;
      start();
      while (cyc - t0 < 6) tick();
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      wait_done(d0 + 1);
      repeat (30) tick();
      chk("ign_done_cnt", done_total - d0, 1);
      chk("ign_pixels", hs_total - h0, NP);
      chk("ign_idle", int'(busy), 0);

      // reset while pixel 2 is presented
      push_frame();
      pix_ready = 1'b0;
      d0 = done_total;
      start();
      wait_valid("rst_v0");
      accept_one();
      wait_valid("rst_v1");
      accept_one();
      wait_valid("rst_v2");
      chk("rst_mid_data", int'(pix_data), int'(exp_pix(2)));
      reset_n = 1'b0;
      #1;
      check_zero("mid_rst");
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      repeat (10) tick();
      chk("rst_no_done", done_total - d0, 0);
      chk("rst_idle", int'(busy), 0);
      push_frame();
      pix_ready = 1'b1;
      start();
      first_valid_at("rst_restart_valid", 2 + RL);
      wait_done(d0 + 1);
      chk("rst_restart_done", done_cyc - t0, NP * (RL + 2) + 1);
      chk("rst_sb_empty", exp_q.size(), 0);

      // back-to-back frames
      tick();
      push_frame();
      push_frame();
      d0 = done_total;
      start();
      begin
         int n;
         n = 0;
         while (!load_done && n < 100) begin
            tick();
            n++;
         end
         if (!load_done) chk("b2b_first_done", 0, 1);
      end
      tick();
      start();
      first_valid_at("b2b_first_valid", 2 + RL);
      wait_done(d0 + 2);
      chk("b2b_done_cyc", done_cyc - t0, NP * (RL + 2) + 1);
      chk("b2b_done_cnt", done_total - d0, 2);
      chk("b2b_sb_empty", exp_q.size(), 0);
      chk("b2b_addr_clr", int'(sram_addr), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sram_pixel_loader.md
# sram_pixel_loader

Downstream consumer of the SRAM image buffer. Once a complete frame has been written, `sram_pixel_loader` reads it back pixel by pixel, in address order. Each pixel is presented to the first neural-network layer over a valid/ready stream. The block owns the SRAM read port and its address counter, and signals completion when the frame is done.

## Interface
- `NUM_PIXELS`, 784: pixels per frame; addresses 0..NUM_PIXELS-1.
- `ADDR_W`, 10: SRAM address width; must satisfy 2^ADDR_W ≥ NUM_PIXELS.
- `PIX_W`, 8: pixel/SRAM data width.
- `READ_LAT`, 2: SRAM read latency in cycles, minimum 1.
- `THRESHOLD`, 128: binarization threshold; used only with `PIXEL_BINARIZE_EN`.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_ready` in 1: one-cycle pulse meaning the frame in SRAM is complete; starts a load.
- `sram_addr` out ADDR_W: read address.
- `sram_rden` out 1: read strobe.
- `sram_q` in PIX_W: SRAM read data.
- `pix_data` out PIX_W: pixel presented to the NN.
- `pix_valid` out 1: `pix_data` is valid.
- `pix_last` out 1: high with `pix_valid` on pixel NUM_PIXELS-1.
- `pix_ready` in 1: NN accepts the pixel.
- `busy` out 1: a load is in progress.
- `load_done` out 1: one-cycle pulse after the last pixel is accepted.

## Operation
- State machine states: `IDLE`, `READ`, `WAIT`, `HOLD`, `DONE`.
- **IDLE**
  - Address counter is 0.
  - `frame_ready` high moves to `READ`.
- **READ** (1 cycle)
  - `sram_rden`=1 with `sram_addr` = current address.
  - Next state is `WAIT`; the wait counter loads READ_LAT-1.
- **WAIT** (READ_LAT cycles)
  - On the last WAIT cycle, `sram_q` is registered into `pix_data`.
  - Next state is `HOLD`.
- **HOLD**
  - `pix_valid`=1. `pix_last`=1 iff address = NUM_PIXELS-1.
  - `pix_data` is stable until `pix_valid && pix_ready`.
  - On handshake with address < NUM_PIXELS-1: address increments, go to `READ`.
  - On handshake with address = NUM_PIXELS-1: go to `DONE`.
- **DONE** (1 cycle)
  - `load_done`=1; address clears to 0; go to `IDLE`.
- `busy`=1 in every state except `IDLE`.
- `frame_ready` is ignored whenever `busy`=1; no queuing.
- `pix_ready` is ignored while `pix_valid`=0.
- The address counter never wraps in service; it is cleared explicitly in `DONE`.
- `sram_addr` is registered and changes only on increment or clear.

## Timing
- Reset values: state `IDLE`; `sram_addr`=0, `sram_rden`=0, `pix_data`=0, `pix_valid`=0, `pix_last`=0, `busy`=0, `load_done`=0.
- Cycle numbering: `frame_ready` sampled high at the end of cycle 0.
  - `READ` (`sram_rden`) occurs in cycle 1.
  - `sram_q` is sampled at the end of cycle 1+READ_LAT.
  - `pix_valid` rises in cycle 2+READ_LAT (cycle 4 at the default READ_LAT=2).
- Per-pixel period with `pix_ready` held high: READ_LAT+2 cycles (4 at the default).
- `load_done` is asserted in the cycle after the final handshake.
  - With `pix_ready` always high, total load time is NUM_PIXELS·(READ_LAT+2)+1 cycles after `frame_ready`.
- `reset_n` asserted mid-load: all outputs return to reset values immediately (asynchronous). The partial frame is abandoned and no `load_done` is issued.
- `frame_ready` in the same cycle as `load_done`: ignored. A new load requires `frame_ready` while in `IDLE`.

## Configuration
- `PIXEL_BINARIZE_EN` defined:
  - The registered pixel is `{PIX_W{1'b1}}` if `sram_q` ≥ THRESHOLD, else 0.
  - Comparison is unsigned, PIX_W bits.
- Undefined: `pix_data` = `sram_q` unmodified, and `THRESHOLD` is unused.
- Timing is identical in both builds.

## Structure
- Shared package `nn_pkg` holds:
  - the `NUM_PIXELS`, `ADDR_W`, `PIX_W` constants;
  - the loader state enum typedef `loader_state_t`;
  - a `pixel_t` typedef (logic [PIX_W-1:0]).
- One natural sub-module: `pixel_addr_counter`.
  - Inputs: `clk`, `reset_n`, `incr`, `clr`.
  - Outputs: `addr`, and `at_last` (addr = NUM_PIXELS-1).
- The FSM, wait counter and output register stay in the top module.

## Test plan
Bench uses NUM_PIXELS=4 and READ_LAT=2, with the SRAM model preloaded {10, 200, 128, 127}.
- **Basic load:** `frame_ready` pulse with `pix_ready`=1.
  - Pixels 10, 200, 128, 127 appear in order; `pix_valid` first high in cycle 4.
  - `pix_last` is high only on 127; `load_done` fires in cycle 17.
- **Backpressure:** hold `pix_ready`=0 for 5 cycles on pixel 1.
  - `pix_data` stays 200 and `pix_valid` stays 1.
  - No `sram_rden` is issued until the handshake.
- **Ignored start:** `frame_ready` pulses at cycle 6 while `busy`.
  - Exactly 4 pixels are delivered and one `load_done` is issued.
- **Reset mid-load:** deassert `reset_n` while `pix_valid`=1 on pixel 2.
  - All outputs go to 0 and state returns to `IDLE`.
  - A subsequent `frame_ready` restarts from address 0.
- **Binarize build (`PIXEL_BINARIZE_EN`, THRESHOLD=128):** stream is 0x00, 0xFF, 0xFF, 0x00.
- **Back-to-back frames:** `frame_ready` one cycle after `load_done`.
  - The second load starts at address 0 and reproduces the same sequence.
